// File: rtl/flash_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | flash_arb_pkg : shared types and field positions for the flash arbiter|
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package flash_arb_pkg;

  localparam int BURST_W = 7;
  localparam int STRAY_W = 8;

  localparam int ST_IDLE_B   = 0;
  localparam int ST_CMD_B    = 1;
  localparam int ST_RDDATA_B = 2;
  localparam int ST_ABORT_B  = 3;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001 << ST_IDLE_B,
    ST_CMD    = 4'b0001 << ST_CMD_B,
    ST_RDDATA = 4'b0001 << ST_RDDATA_B,
    ST_ABORT  = 4'b0001 << ST_ABORT_B
  } state_e;

  localparam int STS_GNT_LSB   = 0;
  localparam int STS_TIMEOUT   = 2;
  localparam int STS_PROTO     = 3;
  localparam int STS_STATE_LSB = 4;
  localparam int STS_STRAY_LSB = 8;

  // A zero burst count still returns one beat.
  function automatic logic [BURST_W-1:0] beats_of(input logic [BURST_W-1:0] bc);
    return (bc == '0) ? BURST_W'(1) : bc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flash_avmm_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | flash_avmm_arbiter_if : AvMM requester / master bundle               |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface flash_avmm_arbiter_if
  import flash_arb_pkg::*;
#(
  parameter int ADDR_W = 29
);
  logic [ADDR_W-1:0]  addr;
  logic               read;
  logic               write;
  logic [BURST_W-1:0] burstcnt;
  logic [31:0]        wrdata;
  logic               lock;
  logic               waitreq;
  logic [31:0]        rddata;
  logic               rddvld;

  modport master (
    output addr, read, write, burstcnt, wrdata, lock,
    input  waitreq, rddata, rddvld
  );

  modport slave (
    input  addr, read, write, burstcnt, wrdata, lock,
    output waitreq, rddata, rddvld
  );
endinterface
`default_nettype wire

// File: rtl/flash_arb_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | flash_arb_rr : 2-way round-robin pick with lock override             |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module flash_arb_rr (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       lock_vld,
  input  logic       lock_owner,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (lock_vld) begin
      grant[lock_owner] = req[lock_owner];
    end else begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/flash_avmm_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | flash_avmm_arbiter : shares the flash AvMM master between two        |
// | requesters (PXE copier, flash-update engine).            rev 1.0     |
// +----------------------------------------------------------------------+
module flash_avmm_arbiter
  import flash_arb_pkg::*;
#(
  parameter int FLASH_ADDR_WIDTH = 28,
  parameter int RSP_TIMEOUT      = 4095
) (
  input  logic                        clk,
  input  logic                        rst_n,
  flash_avmm_arbiter_if.slave         r0,
  flash_avmm_arbiter_if.slave         r1,
  flash_avmm_arbiter_if.master        m,
  input  logic                        sts_clr,
  output logic [31:0]                 arb_status
);

  localparam int              AW      = FLASH_ADDR_WIDTH + 1;
  localparam int              WD_W    = $clog2(RSP_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(RSP_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic                 last_q, last_d;
  logic                 lock_vld_q, lock_vld_d;
  logic                 lock_own_q, lock_own_d;
  logic [BURST_W-1:0]   beats_q, beats_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 timeout_q, timeout_d;
  logic                 proto_q, proto_d;
  logic [STRAY_W-1:0]   stray_q, stray_d;

  logic [1:0]           rd, wr, req, lk, rr_gnt;
  logic                 own, lock_live, stray_hit;
  logic [AW-1:0]        own_addr;
  logic [BURST_W-1:0]   own_bc;
  logic [31:0]          own_wd;

  assign rd        = {r1.read, r0.read};
  assign wr        = {r1.write, r0.write};
  assign req       = rd | wr;
  assign lk        = {r1.lock, r0.lock};
  assign own       = grant_q[1];
  assign own_addr  = own ? r1.addr : r0.addr;
  assign own_bc    = own ? r1.burstcnt : r0.burstcnt;
  assign own_wd    = own ? r1.wrdata : r0.wrdata;
  assign lock_live = lock_vld_q & lk[lock_own_q];
  assign stray_hit = m.rddvld & (state_q != ST_RDDATA);

  flash_arb_rr u_rr (
    .req        (req),
    .last_grant (last_q),
    .lock_vld   (lock_live),
    .lock_owner (lock_own_q),
    .grant      (rr_gnt)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
    beats_d    = beats_q;
    wd_d       = wd_q;
    timeout_d  = sts_clr ? 1'b0 : timeout_q;
    proto_d    = sts_clr ? 1'b0 : proto_q;
    stray_d    = sts_clr ? '0 : stray_q;

    unique case (state_q)
      ST_IDLE: begin
        lock_vld_d = lock_live;
        if (rr_gnt != 2'b00) begin
          grant_d = rr_gnt;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (!req[own]) begin
          state_d    = ST_IDLE;
          grant_d    = 2'b00;
          lock_vld_d = lk[own];
          lock_own_d = own;
        end else begin
          if (rd[own] && wr[own]) proto_d = 1'b1;
          if (!m.waitreq) begin
            last_d = own;
            if (rd[own]) begin
              beats_d = beats_of(own_bc);
              wd_d    = '0;
              state_d = ST_RDDATA;
            end else begin
              state_d    = ST_IDLE;
              grant_d    = 2'b00;
              lock_vld_d = lk[own];
              lock_own_d = own;
            end
          end
        end
      end
      ST_RDDATA: begin
        if (m.rddvld) begin
          beats_d = beats_q - BURST_W'(1);
          wd_d    = '0;
          if (beats_q == BURST_W'(1)) begin
            state_d    = ST_IDLE;
            grant_d    = 2'b00;
            lock_vld_d = lk[own];
            lock_own_d = own;
          end
        end else if (wd_q == WD_LAST) begin
          // A hung response must not let a locked owner starve the other side.
          timeout_d  = 1'b1;
          state_d    = ST_ABORT;
          grant_d    = 2'b00;
          lock_vld_d = 1'b0;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_ABORT: begin
        beats_d    = '0;
        lock_vld_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase

    if (stray_hit) begin
      if (sts_clr)                  stray_d = STRAY_W'(1);
      else if (stray_q != '1)       stray_d = stray_q + STRAY_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= 2'b00;
      last_q     <= 1'b1;
      lock_vld_q <= 1'b0;
      lock_own_q <= 1'b0;
      beats_q    <= '0;
      wd_q       <= '0;
      timeout_q  <= 1'b0;
      proto_q    <= 1'b0;
      stray_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
      beats_q    <= beats_d;
      wd_q       <= wd_d;
      timeout_q  <= timeout_d;
      proto_q    <= proto_d;
      stray_q    <= stray_d;
    end
  end

  // Command path is a straight mux so the requester sees m_waitreq with no added latency.
  always_comb begin
    m.addr     = '0;
    m.read     = 1'b0;
    m.write    = 1'b0;
    m.burstcnt = '0;
    m.wrdata   = '0;
    r0.waitreq = 1'b1;
    r1.waitreq = 1'b1;
    if (state_q == ST_CMD) begin
      m.addr     = own_addr;
      m.read     = rd[own];
      m.write    = wr[own] & ~rd[own];
      m.burstcnt = own_bc;
      m.wrdata   = own_wd;
      r0.waitreq = own ? 1'b1 : m.waitreq;
      r1.waitreq = own ? m.waitreq : 1'b1;
    end
  end

  assign m.lock     = 1'b0;
  assign r0.rddata  = m.rddata;
  assign r1.rddata  = m.rddata;
  assign r0.rddvld  = m.rddvld & (state_q == ST_RDDATA) & grant_q[0];
  assign r1.rddvld  = m.rddvld & (state_q == ST_RDDATA) & grant_q[1];

  assign arb_status = {16'h0000, stray_q, state_q, proto_q, timeout_q, grant_q};

endmodule
`default_nettype wire
